spi_tx_byte_feeder: RTL
=======================

Name: spi_tx_byte_feeder

Overview:
Upstream stage of spi_master2v0. Buffers command, address and data bytes from the controller in a small FIFO and serializes them MSB-first, one bit per clk_i, onto the master's MOSI_i input. The frame length in bits matches the master's data_size_i. The block produces the bit stream the master forwards on MOSI_o. It also reports frame completion and underrun.

Parameters:
DATA_W, 8, byte width shifted per FIFO entry
FIFO_DEPTH, 4, FIFO entries (power of 2, >=2)
LEN_W, 13, frame length width in bits (matches data_size_i)

Ports:
clk_i  in  1  base clock, rising edge
rst_i  in  1  asynchronous reset, active-high
start_i  in  1  frame start request, sampled in IDLE only
len_i  in  LEN_W  frame length in bits, latched on accepted start
wr_data_i  in  DATA_W  byte to enqueue
wr_valid_i  in  1  enqueue request
wr_ready_o  out  1  FIFO not full
mosi_o  out  1  serial bit to spi_master2v0 MOSI_i
busy_o  out  1  frame in progress
done_o  out  1  one-cycle pulse when the frame ends
underrun_o  out  1  sticky: FIFO was empty when a byte was needed
fifo_level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, rst_i=1): FIFO emptied, state IDLE, shreg=0, bit_idx=0, cnt=0. Outputs: mosi_o=0, busy_o=0, done_o=0, underrun_o=0, wr_ready_o=1, fifo_level_o=0. Reset mid-frame aborts immediately with no done_o.
- FIFO push: occurs on wr_valid_i && wr_ready_o. wr_ready_o = (level != FIFO_DEPTH), combinational. Pointers wrap modulo FIFO_DEPTH.
- Push and pop in the same cycle: level unchanged. Pop on an empty FIFO does not bypass the byte being pushed that cycle; that byte is stored and underrun applies.
- mosi_o = shreg[DATA_W-1], registered.
- FSM states: IDLE, SHIFT.
- IDLE:
  - start_i=1 and len_i!=0: at edge k, pop FIFO head into shreg, cnt<=len_i-1, bit_idx<=0, underrun_o<=0, go to SHIFT.
  - Empty FIFO at that edge: shreg<=0 and underrun_o<=1.
  - Frame bit n appears on mosi_o after edge k+n.
  - start_i=1 and len_i=0: no shift; done_o=1 for the cycle after the edge; remain IDLE.
- SHIFT (busy_o=1):
  - cnt==0: go to IDLE, shreg<=0, done_o<=1 for one cycle.
  - Otherwise: cnt<=cnt-1.
    - If bit_idx==DATA_W-1: pop next byte into shreg (0 plus underrun_o<=1 if empty) and set bit_idx<=0.
    - Else: shreg<<=1 and bit_idx++.
  - Exactly len_i bits are driven.
  - If len_i is not a multiple of DATA_W, the unsent LSBs of the last byte are discarded. No extra pop occurs.
  - Underrun does not stop the frame; the master keeps clocking and zeros are sent.
- start_i in SHIFT is ignored. Pushes are allowed during SHIFT.
- done_o and busy_o are never high in the same cycle.

Test Plan:
1. Push 0x0B,0xBB,0xBB,0xBB; start with len_i=32 -> mosi_o carries 00001011 10111011 10111011 10111011 over 32 cycles; one done_o pulse; underrun_o=0; level 0.
2. Push 0xA5; start with len_i=4 -> mosi_o=1,0,1,0; done_o after 4 bits; FIFO empty; 0x5 nibble dropped; next frame pops a new byte.
3. Push 0xFF only; start with len_i=16 -> 8 ones then 8 zeros; underrun_o=1 from the second byte onward and held until the next accepted start.
4. Push 4 bytes with no start -> wr_ready_o=0 and level=4; 5th push ignored. Start with len_i=8 -> after the first pop, level=3 and ready=1.
5. Assert rst_i during bit 5 of a 24-bit frame -> all outputs at reset values immediately; no done_o; FIFO empty.
6. Start with len_i=0 -> done_o pulse; busy_o stays 0; FIFO level unchanged.

Source files
------------

// File: rtl/spi_tx_byte_feeder_if.sv
// Handshake/bus bundle between the controller and spi_tx_byte_feeder.
// The master modport is the controller side. The slave modport is the feeder.
interface spi_tx_byte_feeder_if #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 13
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic              start_i;
  logic [LEN_W-1:0]  len_i;
  logic [DATA_W-1:0] wr_data_i;
  logic              wr_valid_i;
  logic              wr_ready_o;
  logic              mosi_o;
  logic              busy_o;
  logic              done_o;
  logic              underrun_o;
  logic [LVL_W-1:0]  fifo_level_o;

  modport master (
    output start_i, len_i, wr_data_i, wr_valid_i,
    input  wr_ready_o, mosi_o, busy_o, done_o, underrun_o, fifo_level_o
  );

  modport slave (
    input  start_i, len_i, wr_data_i, wr_valid_i,
    output wr_ready_o, mosi_o, busy_o, done_o, underrun_o, fifo_level_o
  );
endinterface

// File: rtl/spi_tx_byte_feeder.sv
// Buffers bytes in a small FIFO and shifts them out MSB-first, one bit per clock,
// to feed the MOSI_i input of spi_master2v0. It also flags frame completion and FIFO underrun.
module spi_tx_byte_feeder #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 13
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  spi_tx_byte_feeder_if.slave   bus
);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int BIDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIDX_W-1:0] LAST_BIT = BIDX_W'(DATA_W - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wrPtr_q, rdPtr_q;
  logic [LVL_W-1:0]    level_q;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [BIDX_W-1:0]   bitIdx_q, bitIdx_d;
  logic                done_q, done_d;
  logic                underrun_q, underrun_d;
  logic                push, popReq, pop, fifoEmpty;
  logic [DATA_W-1:0]   headByte;

  assign fifoEmpty       = (level_q == '0);
  assign bus.wr_ready_o  = (level_q != LVL_W'(FIFO_DEPTH));
  assign push            = bus.wr_valid_i && bus.wr_ready_o;
  // An empty FIFO never bypasses a same-cycle push; the consumer sees zero instead.
  assign pop             = popReq && !fifoEmpty;
  assign headByte        = fifoEmpty ? '0 : mem_q[rdPtr_q];

  assign bus.mosi_o       = shreg_q[DATA_W-1];
  assign bus.busy_o       = (state_q == SHIFT);
  assign bus.done_o       = done_q;
  assign bus.underrun_o   = underrun_q;
  assign bus.fifo_level_o = level_q;

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wrPtr_q] <= bus.wr_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + PTR_W'(1);
      if (pop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
      if (push && !pop)      level_q <= level_q + LVL_W'(1);
      else if (pop && !push) level_q <= level_q - LVL_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    bitIdx_d   = bitIdx_q;
    done_d     = 1'b0;
    underrun_d = underrun_q;
    popReq     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          if (bus.len_i == '0) begin
            done_d = 1'b1;
          end else begin
            popReq     = 1'b1;
            shreg_d    = headByte;
            underrun_d = fifoEmpty;
            cnt_d      = bus.len_i - LEN_W'(1);
            bitIdx_d   = '0;
            state_d    = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          shreg_d = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
          if (bitIdx_q == LAST_BIT) begin
            popReq   = 1'b1;
            shreg_d  = headByte;
            bitIdx_d = '0;
            if (fifoEmpty) underrun_d = 1'b1;
          end else begin
            shreg_d  = shreg_q << 1;
            bitIdx_d = bitIdx_q + BIDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      cnt_q      <= '0;
      bitIdx_q   <= '0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      bitIdx_q   <= bitIdx_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
    end
  end
endmodule
